// File: rtl/mano_timing_ctrl_pkg.sv
// Shared phase encodings and per-opcode completion timing for the Mano timing controller.
// Pure constants and a helper; no state.
package mano_timing_ctrl_pkg;

  localparam int SEQWIDTH = 4;

  localparam logic [2:0] PH_IDLE     = 3'd0;
  localparam logic [2:0] PH_FETCH    = 3'd1;
  localparam logic [2:0] PH_DECODE   = 3'd2;
  localparam logic [2:0] PH_INDIRECT = 3'd3;
  localparam logic [2:0] PH_EXECUTE  = 3'd4;
  localparam logic [2:0] PH_INTR     = 3'd5;

  // Final timing step of each instruction class.
  localparam logic [3:0] LAST_T_MRI     = 4'd5;  // AND, ADD, LDA, BSA
  localparam logic [3:0] LAST_T_STA_BUN = 4'd4;
  localparam logic [3:0] LAST_T_ISZ     = 4'd6;
  localparam logic [3:0] LAST_T_REG     = 4'd3;  // register-reference / IO
  localparam logic [3:0] LAST_T_INTR    = 4'd2;

  function automatic logic [3:0] last_t(input logic [2:0] op);
    case (op)
      3'd3, 3'd4: last_t = LAST_T_STA_BUN;
      3'd6:       last_t = LAST_T_ISZ;
      3'd7:       last_t = LAST_T_REG;
      default:    last_t = LAST_T_MRI;
    endcase
  endfunction

endpackage

// File: rtl/mano_tdec.sv
// One-hot decode of the sequence counter, forced to zero when disabled.
// Latency: combinational. Backpressure: none.
// Used by the timing controller so T outputs vanish while the machine is stopped.
module mano_tdec #(
  parameter int SEQW = 4,
  parameter int NT   = 16
) (
  input  logic [SEQW-1:0] t,
  input  logic            en,
  output logic [NT-1:0]   tdec
);

  always_comb begin
    tdec = '0;
    for (int i = 0; i < NT; i++) begin
      if (en && (32'(t) == i)) tdec[i] = 1'b1;
    end
  end

endmodule

// File: rtl/mano_timing_ctrl.sv
// Mano basic-computer timing/control: phase FSM, SC control, T/D decode, sequence checker.
// Latency: decodes and SC control combinational, phase/flags registered. Backpressure: none.
// Interrupt cycle is built only when MANO_INTR_EN is defined; otherwise R stays 0.
module mano_timing_ctrl
  import mano_timing_ctrl_pkg::*;
#(
  parameter int SEQW = SEQWIDTH,
  parameter int NT   = 2**SEQW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SEQW-1:0] t,
  input  logic            start,
  input  logic            ir_i,
  input  logic [2:0]      ir_op,
  input  logic            hlt,
  input  logic            intr_req,
  input  logic            ien,
  output logic            sc_inc,
  output logic            sc_clr,
  output logic [NT-1:0]   tdec,
  output logic [7:0]      d_dec,
  output logic [2:0]      phase,
  output logic            running,
  output logic            r_flag,
  output logic            done,
  output logic            seq_err
);

  localparam logic [SEQW-1:0] T1  = SEQW'(1);
  localparam logic [SEQW-1:0] T2  = SEQW'(2);
  localparam logic [SEQW-1:0] T3  = SEQW'(3);
  localparam logic [SEQW-1:0] ONE = SEQW'(1);

  logic [2:0]      phase_q, phase_d;
  logic            s_q, s_d;
  logic            r_q, r_d, r_eff;
  logic [SEQW-1:0] t_exp_q, t_exp_d;
  logic            err_q, err_d;
  logic [SEQW-1:0] lt;
  logic            instr_end, intr_end, cycle_end, halt;

  assign lt        = SEQW'(last_t(ir_op));
  assign instr_end = s_q && (phase_q == PH_EXECUTE) && (t == lt);
  assign intr_end  = s_q && (phase_q == PH_INTR) && (t == SEQW'(LAST_T_INTR));
  assign cycle_end = instr_end | intr_end;
  assign halt      = instr_end && (ir_op == 3'd7) && hlt;

  assign sc_clr  = ~s_q | cycle_end;
  assign sc_inc  = s_q & ~sc_clr;
  assign done    = cycle_end;
  assign running = s_q;
  assign phase   = phase_q;
  assign r_flag  = r_q;
  assign seq_err = err_q;
  assign d_dec   = 8'b1 << ir_op;

`ifdef MANO_INTR_EN
  // A request seen during the completion cycle itself still diverts into INTR.
  assign r_eff = r_q | (s_q & ien & intr_req & (t > T2));
  assign r_d   = (halt | intr_end) ? 1'b0 : r_eff;
`else
  logic unused_intr;
  assign unused_intr = ien ^ intr_req;
  assign r_eff       = 1'b0;
  assign r_d         = 1'b0;
`endif

  always_comb begin
    phase_d = phase_q;
    s_d     = s_q;
    case (phase_q)
      PH_IDLE: begin
        if (start) begin
          phase_d = PH_FETCH;
          s_d     = 1'b1;
        end
      end
      PH_FETCH:    if (t == T1) phase_d = PH_DECODE;
      PH_DECODE: begin
        if (t == T2) phase_d = (ir_op != 3'd7 && ir_i) ? PH_INDIRECT : PH_EXECUTE;
      end
      PH_INDIRECT: if (t == T3) phase_d = PH_EXECUTE;
      PH_EXECUTE: begin
        if (halt) begin
          phase_d = PH_IDLE;
          s_d     = 1'b0;
        end else if (instr_end) begin
          phase_d = r_eff ? PH_INTR : PH_FETCH;
        end
      end
      PH_INTR:     if (intr_end) phase_d = PH_FETCH;
      default: begin
        phase_d = PH_IDLE;
        s_d     = 1'b0;
      end
    endcase
  end

  // t_exp mirrors what the external counter should hold, so any skip or stall is caught.
  assign t_exp_d = sc_inc ? (t_exp_q + ONE) : '0;
  assign err_d   = err_q | (s_q && (t != t_exp_q));

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= PH_IDLE;
      s_q     <= 1'b0;
      r_q     <= 1'b0;
      t_exp_q <= '0;
      err_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      s_q     <= s_d;
      r_q     <= r_d;
      t_exp_q <= t_exp_d;
      err_q   <= err_d;
    end
  end

  mano_tdec #(.SEQW(SEQW), .NT(NT)) u_tdec (
    .t    (t),
    .en   (s_q),
    .tdec (tdec)
  );

endmodule

// File: tb/tb_mano_timing_ctrl.sv
// Bench for mano_timing_ctrl: drives a sequence counter that obeys sc_clr/sc_inc and checks
// phases, decodes and flags against a table and an instruction-level model.
module tb_mano_timing_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, ir_i, hlt, intr_req, ien;
  logic [3:0]  t;
  logic [2:0]  ir_op;
  logic        sc_inc, sc_clr, running, r_flag, done, seq_err;
  logic [15:0] tdec;
  logic [7:0]  d_dec;
  logic [2:0]  phase;

  logic [3:0]  sc = 4'd0;
  logic        skip4 = 1'b0;
  int          total = 0;
  int          bad = 0;

  // Completion step per opcode: ops 0,1,2,5 -> T5, 3,4 -> T4, 6 -> T6, 7 -> T3.
  int lt_tab[8] = '{5, 5, 5, 4, 4, 5, 6, 3};

  typedef struct {
    logic [2:0]  op;
    logic        ind;
    logic        h;
    int          len;
    logic [31:0] ph;   // phase of cycle k in nibble k
    logic        run;
  } vec_t;
  vec_t vt[9];

  always #5 clk = ~clk;

  mano_timing_ctrl #(.SEQW(4), .NT(16)) dut (
    .clk(clk), .rst(rst), .t(t), .start(start), .ir_i(ir_i), .ir_op(ir_op),
    .hlt(hlt), .intr_req(intr_req), .ien(ien),
    .sc_inc(sc_inc), .sc_clr(sc_clr), .tdec(tdec), .d_dec(d_dec), .phase(phase),
    .running(running), .r_flag(r_flag), .done(done), .seq_err(seq_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: the external counter follows the controls seen before the edge.
  task automatic step();
    logic c, i;
    @(negedge clk);
    c = sc_clr;
    i = sc_inc;
    @(posedge clk);
    #1;
    if (c === 1'b1) sc = 4'd0;
    else if (i === 1'b1) sc = (skip4 && sc == 4'd3) ? 4'd5 : sc + 4'd1;
    t = sc;
  endtask

  task automatic reset_start();
    rst = 1'b1; start = 1'b0; hlt = 1'b0; ien = 1'b0; intr_req = 1'b0; skip4 = 1'b0;
    step();
    step();
    rst = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  function automatic logic [2:0] exp_phase(input int k, input logic [2:0] op, input logic ind);
    if (k < 2) return 3'd1;
    if (k == 2) return 3'd2;
    if (k == 3 && ind && op != 3'd7) return 3'd3;
    return 3'd4;
  endfunction

  task automatic run_instr(input logic [2:0] op, input logic ind, input logic h);
    int l;
    l = lt_tab[op];
    for (int k = 0; k <= l; k++) begin
      ir_op = op; ir_i = ind; hlt = h;
      start = 1'($urandom_range(0, 1));
      intr_req = 1'($urandom_range(0, 1));
      #1;
      chk("m_phase", 32'(phase), 32'(exp_phase(k, op, ind)));
      chk("m_ctl", 32'({running, done, sc_clr, sc_inc}), 32'({1'b1, k == l, k == l, k != l}));
      chk("m_tdec", 32'(tdec), 32'(1) << k);
      chk("m_ddec", 32'(d_dec), 32'(1) << op);
      step();
    end
    start = 1'b0; intr_req = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: total=%0d", total);
    $fatal(1);
  end

  initial begin
    logic [31:0] ph;
    int          n;
    logic        seen;
    logic [2:0]  op;
    logic        ind, h;

    vt[0] = '{3'd1, 1'b0, 1'b0, 6, 32'h00444211, 1'b1};
    vt[1] = '{3'd6, 1'b1, 1'b0, 7, 32'h04443211, 1'b1};
    vt[2] = '{3'd7, 1'b1, 1'b1, 4, 32'h00004211, 1'b0};
    vt[3] = '{3'd3, 1'b0, 1'b0, 5, 32'h00044211, 1'b1};
    vt[4] = '{3'd4, 1'b1, 1'b0, 5, 32'h00043211, 1'b1};
    vt[5] = '{3'd0, 1'b1, 1'b0, 6, 32'h00443211, 1'b1};
    vt[6] = '{3'd2, 1'b0, 1'b0, 6, 32'h00444211, 1'b1};
    vt[7] = '{3'd5, 1'b1, 1'b0, 6, 32'h00443211, 1'b1};
    vt[8] = '{3'd7, 1'b1, 1'b0, 4, 32'h00004211, 1'b1};

    t = 4'd0; rst = 1'b1; start = 1'b0; ir_i = 1'b0; ir_op = 3'd0;
    hlt = 1'b0; intr_req = 1'b0; ien = 1'b0;

    // Reset state, with a nonzero t to show the T decode stays dark.
    step();
    step();
    t = 4'd3;
    #1;
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_ctl", 32'({running, done, sc_clr, sc_inc, r_flag, seq_err}), 32'b001000);
    chk("rst_tdec", 32'(tdec), 32'd0);
    t = sc;

    // Table: instruction length, phase trace, state after completion.
    for (int v = 0; v < 9; v++) begin
      reset_start();
      ir_op = vt[v].op; ir_i = vt[v].ind; hlt = vt[v].h;
      n = 0; ph = '0; seen = 1'b0;
      while (!seen && n < 8) begin
        #1;
        ph = ph | (32'(phase) << (4 * n));
        seen = done;
        n++;
        step();
      end
      #1;
      chk($sformatf("v%0d_len", v), 32'(n), 32'(vt[v].len));
      chk($sformatf("v%0d_phases", v), ph, vt[v].ph);
      chk($sformatf("v%0d_run", v), 32'(running), 32'(vt[v].run));
      chk($sformatf("v%0d_next", v), 32'(phase), vt[v].run ? 32'd1 : 32'd0);
      chk($sformatf("v%0d_clr", v), 32'(sc_clr), 32'(!vt[v].run));
      step();
      #1;
      chk($sformatf("v%0d_clr2", v), 32'(sc_clr), 32'(!vt[v].run));
    end
    hlt = 1'b0;

    // Counter skips T4: error latches and survives until reset.
    reset_start();
    ir_op = 3'd1; ir_i = 1'b0; skip4 = 1'b1;
    repeat (4) step();
    #1;
    chk("skip_t5", 32'(tdec), 32'h20);
    chk("skip_err_pre", 32'(seq_err), 32'd0);
    step();
    skip4 = 1'b0;
    #1;
    chk("skip_err", 32'(seq_err), 32'd1);
    repeat (8) step();
    #1;
    chk("skip_err_sticky", 32'(seq_err), 32'd1);
    rst = 1'b1;
    step();
    #1;
    chk("skip_err_rst", 32'(seq_err), 32'd0);
    rst = 1'b0;

    // Interrupt request at T4 of a STA-class instruction.
    reset_start();
    ir_op = 3'd3; ir_i = 1'b0; ien = 1'b1;
    repeat (4) step();
    intr_req = 1'b1;
    #1;
    chk("int_t4_done", 32'({phase, done}), 32'({3'd4, 1'b1}));
    step();
    intr_req = 1'b0;
`ifdef MANO_INTR_EN
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("intr_cyc", 32'({phase, r_flag, done, sc_clr}), 32'({3'd5, 1'b1, k == 2, k == 2}));
      chk("intr_tdec", 32'(tdec), 32'(1) << k);
      step();
    end
`endif
    #1;
    chk("int_after", 32'({phase, r_flag, running}), 32'({3'd1, 1'b0, 1'b1}));
    chk("int_after_tdec", 32'(tdec), 32'd1);
    ien = 1'b0;

`ifdef MANO_INTR_EN
    // Halt wins over a pending interrupt in the same completion cycle.
    reset_start();
    ir_op = 3'd7; ir_i = 1'b0; hlt = 1'b1; ien = 1'b1; intr_req = 1'b1;
    repeat (3) step();
    #1;
    chk("hlt_r_done", 32'(done), 32'd1);
    step();
    #1;
    chk("hlt_r_after", 32'({phase, r_flag, running}), 32'({3'd0, 1'b0, 1'b0}));
    hlt = 1'b0; ien = 1'b0; intr_req = 1'b0;
`endif

    // Reset in the middle of execute aborts without a done pulse.
    reset_start();
    ir_op = 3'd1; ir_i = 1'b0;
    repeat (4) step();
    #1;
    chk("mid_pre", 32'({phase, tdec}), 32'({3'd4, 16'h0010}));
    rst = 1'b1;
    step();
    #1;
    chk("mid_rst", 32'({phase, done, sc_clr, running}), 32'({3'd0, 1'b0, 1'b1, 1'b0}));
    rst = 1'b0;

    // Random instruction stream with stray start/intr_req pulses, ien held low.
    reset_start();
    for (int j = 0; j < 40; j++) begin
      op  = 3'($urandom_range(0, 7));
      ind = 1'($urandom_range(0, 1));
      h   = (op == 3'd7) && ($urandom_range(0, 3) == 0);
      run_instr(op, ind, h);
      if (h) begin
        #1;
        chk("r_halt", 32'({phase, running, sc_clr, sc_inc, done, tdec}),
            32'({3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000}));
        start = 1'b1;
        step();
        start = 1'b0;
      end
    end
    #1;
    chk("r_seq_err", 32'(seq_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
